// File: rtl/uart_rx_fifo_axis_pkg.sv
// Shared definitions for the UART receive path: bit-period math, FSM encoding
// and the default end-of-packet value.
package uart_rx_fifo_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_EOP_BYTE = 8'h0A;

  // Clocks per bit, truncated.
  function automatic int calc_div(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  // Counter must hold DIV-1.
  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_axis_core.sv
// Serial receiver: 2-flop synchronizer, start/data/stop sampling FSM and the
// LSB-first shift register. Emits a one-cycle push request or frame error.
module uart_rx_core
  import uart_rx_fifo_axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] rx_word,
  output logic             rx_push,
  output logic             frame_err
);

  localparam int CNT_W = cnt_width(DIV);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic             rx_meta_reg;
  logic             rx_s_reg;
  logic             rx_prev_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] bit_sel;
  logic             sample_en;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign sample_en = (state_reg == ST_DATA) && (cnt_reg == '0);
  assign rx_word   = shift_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    rx_push    = 1'b0;
    frame_err  = 1'b0;

    if (sample_en) begin
      shift_next = (shift_reg & ~bit_sel) | ({WIDTH{rx_s_reg}} & bit_sel);
    end

    case (state_reg)
      ST_IDLE: begin
        if (rx_prev_reg && !rx_s_reg) begin
          cnt_next   = HALF_LOAD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (!rx_s_reg) begin
          cnt_next   = BIT_LOAD;
          idx_next   = '0;
          state_next = ST_DATA;
        end else begin
          // Line came back high at mid-start: treat as a glitch.
          state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          cnt_next = BIT_LOAD;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx_reg + IDX_ONE;
          end
        end
      end
      ST_STOP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rx_s_reg) begin
          rx_push    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          frame_err  = 1'b1;
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_fifo_axis.sv
// UART receiver feeding a first-word-fall-through FIFO presented as an
// AXI-Stream master, with TLAST on a configurable end-of-packet word.
module uart_rx_fifo_axis
  import uart_rx_fifo_axis_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 8,
  parameter int               CLK_RATE = 50000000,
  parameter int               BAUD     = 115200,
  parameter bit               EOP_EN   = 1'b1,
  parameter logic [WIDTH-1:0] EOP_BYTE = WIDTH'(DEFAULT_EOP_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  output logic             m_axis_last,
  input  logic             m_axis_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int DIV    = calc_div(CLK_RATE, BAUD);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  rx_word;
  logic              rx_push;
  logic              word_last;
  logic              pop;
  logic              push_ok;
  logic [WIDTH:0]    head;
  logic [WIDTH:0]    mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;

  uart_rx_core #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_word  (rx_word),
    .rx_push  (rx_push),
    .frame_err(frame_err)
  );

  assign word_last = EOP_EN && (rx_word == EOP_BYTE);
  assign pop       = m_axis_valid && m_axis_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = rx_push && ((count_reg < FULL_CNT) || pop);
  assign overrun   = rx_push && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {word_last, rx_word};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head         = mem[rd_ptr_reg];
  assign m_axis_valid = (count_reg != '0);
  assign m_axis_data  = m_axis_valid ? head[WIDTH-1:0] : '0;
  assign m_axis_last  = m_axis_valid && head[WIDTH];

endmodule

// File: tb/tb_uart_rx_fifo_axis.sv
// Randomized/directed bench for uart_rx_fifo_axis with a queue scoreboard and
// a decoupled AXIS monitor.
module tb_uart_rx_fifo_axis;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int CLK_RATE = 1600000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLKS = CLK_RATE / BAUD;
  // Negedge index (from start-bit drive) of the cycle the DUT samples the stop bit.
  localparam int STOP_CYC = 9 * BIT_CLKS + BIT_CLKS / 2 + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             uart_rx = 1'b1;
  logic             m_axis_ready = 1'b0;
  logic [WIDTH-1:0] m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic             frame_err;
  logic             overrun;

  uart_rx_fifo_axis #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .CLK_RATE(CLK_RATE),
    .BAUD    (BAUD),
    .EOP_EN  (1'b1),
    .EOP_BYTE(8'h0A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .m_axis_data (m_axis_data),
    .m_axis_valid(m_axis_valid),
    .m_axis_last (m_axis_last),
    .m_axis_ready(m_axis_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  int         mdl_cnt = 0;
  int         exp_fe = 0;
  int         exp_ovr = 0;
  int         seen_fe = 0;
  int         seen_ovr = 0;
  int         ready_mode = 0;  // 0 = low, 1 = high, 2 = random

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input bit force_ready);
    @(negedge clk);
    case (ready_mode)
      0:       m_axis_ready = 1'b0;
      1:       m_axis_ready = 1'b1;
      default: m_axis_ready = 1'($urandom_range(0, 1));
    endcase
    if (force_ready) m_axis_ready = 1'b1;
  endtask

  // Model: a good frame is stored unless the FIFO already holds DEPTH words and
  // nothing leaves it in the same cycle.
  task automatic send_byte(input logic [7:0] b, input bit stop_val, input int hold_low,
                           input bit pop_at_stop);
    bit accept = 1'b0;
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      tick(pop_at_stop && (c == STOP_CYC));
      if (c < BIT_CLKS) uart_rx = 1'b0;
      else if (c < 9 * BIT_CLKS) uart_rx = b[c / BIT_CLKS - 1];
      else uart_rx = stop_val;
      if (c == STOP_CYC) begin
        #1;
        accept = stop_val && ((mdl_cnt < DEPTH) || (m_axis_ready && mdl_cnt > 0));
        if (accept) begin
          exp_q.push_back({(b == 8'h0A), b});
          mdl_cnt++;
        end
        if (stop_val && !accept) exp_ovr++;
        if (!stop_val) exp_fe++;
        #1;
        check("overrun_at_stop", int'(overrun), int'(stop_val && !accept));
        check("frame_err_at_stop", int'(frame_err), int'(!stop_val));
      end
      if (c == STOP_CYC + 1 && accept) begin
        #2;
        check("valid_after_push", int'(m_axis_valid), 1);
      end
      if (c == STOP_CYC + 2 && accept && ready_mode == 1) begin
        #3;
        check("valid_one_cycle", int'(m_axis_valid), 0);
      end
    end
    repeat (hold_low) begin
      tick(1'b0);
      uart_rx = 1'b0;
    end
    repeat (3) begin
      tick(1'b0);
      uart_rx = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1'b0);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
    end
    repeat (2) tick(1'b0);
    #2;
    check("empty_after_drain", int'(m_axis_valid), 0);
  endtask

  initial begin : monitor
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       prst = 1'b0;
    logic [8:0] pbeat = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (frame_err) seen_fe++;
      if (overrun) seen_ovr++;
      check("err_exclusive", int'(frame_err && overrun), 0);
      if (rst && prst && pv && !pr) begin
        check("stall_valid", int'(m_axis_valid), 1);
        check("stall_stable", int'({m_axis_last, m_axis_data}), int'(pbeat));
      end
      if (!m_axis_valid) begin
        check("idle_gated", int'({m_axis_last, m_axis_data}), 0);
      end else if (m_axis_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data=%02h last=%0d, required no beat",
                   m_axis_data, m_axis_last);
        end else begin
          e = exp_q.pop_front();
          mdl_cnt--;
          $display("beat data=%02h last=%0d expect data=%02h last=%0d",
                   m_axis_data, m_axis_last, e[7:0], e[8]);
          check("beat", int'({m_axis_last, m_axis_data}), int'(e));
        end
      end
      pv    = m_axis_valid;
      pr    = m_axis_ready;
      prst  = rst;
      pbeat = {m_axis_last, m_axis_data};
    end
  end

  initial begin : stimulus
    logic [7:0] rb;
    bit         rfe;
    ready_mode = 0;
    repeat (3) tick(1'b0);
    #2;
    check("reset_valid", int'(m_axis_valid), 0);
    check("reset_data", int'(m_axis_data), 0);
    check("reset_last", int'(m_axis_last), 0);
    check("reset_errs", int'({frame_err, overrun}), 0);
    tick(1'b0);
    rst = 1'b1;
    repeat (4) tick(1'b0);

    // Single byte with the consumer always ready.
    ready_mode = 1;
    send_byte(8'hA5, 1'b1, 0, 1'b0);
    drain();

    // EOP tagging while stalled.
    ready_mode = 0;
    send_byte(8'h41, 1'b1, 0, 1'b0);
    send_byte(8'h0A, 1'b1, 0, 1'b0);
    send_byte(8'h42, 1'b1, 0, 1'b0);
    repeat (10) tick(1'b0);
    drain();

    // Overrun: nine bytes into an eight-deep stalled FIFO.
    ready_mode = 0;
    for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1, 0, 1'b0);
    drain();

    // Frame error with the line held low afterwards, then a clean byte.
    ready_mode = 1;
    send_byte(8'h3C, 1'b0, 40, 1'b0);
    send_byte(8'h55, 1'b1, 0, 1'b0);
    drain();

    // Short glitch on an idle line.
    tick(1'b0);
    uart_rx = 1'b0;
    repeat (3) tick(1'b0);
    uart_rx = 1'b1;
    repeat (40) tick(1'b0);
    #2;
    check("glitch_no_valid", int'(m_axis_valid), 0);

    // Reset mid-frame with a word waiting in the FIFO.
    ready_mode = 0;
    send_byte(8'h5A, 1'b1, 0, 1'b0);
    tick(1'b0);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) tick(1'b0);
    uart_rx = 1'b1;
    repeat (3 * BIT_CLKS) tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    mdl_cnt = 0;
    #1;
    check("rst_mid_valid", int'(m_axis_valid), 0);
    check("rst_mid_data", int'(m_axis_data), 0);
    check("rst_mid_last", int'(m_axis_last), 0);
    check("rst_mid_errs", int'({frame_err, overrun}), 0);
    repeat (3) tick(1'b0);
    rst = 1'b1;
    repeat (3) tick(1'b0);
    #2;
    check("post_rst_empty", int'(m_axis_valid), 0);
    ready_mode = 1;
    send_byte(8'h81, 1'b1, 0, 1'b0);
    drain();

    // Full FIFO with a pop landing on the ninth push.
    ready_mode = 0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b1, 0, 1'b0);
    send_byte(8'h18, 1'b1, 0, 1'b1);
    drain();

    // Random bytes, random back-pressure, occasional bad stop bits.
    ready_mode = 2;
    for (int i = 0; i < 16; i++) begin
      rb  = 8'($urandom);
      rfe = ($urandom_range(0, 5) == 0);
      send_byte(rb, !rfe, rfe ? 20 : 0, 1'b0);
    end
    drain();

    check("frame_err_total", seen_fe, exp_fe);
    check("overrun_total", seen_ovr, exp_ovr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
